// File: rtl/game_pkg.sv
// Shared definitions for the LED sequence game: FSM state encoding and the
// LFSR seed/tap constants used by game_lfsr.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADD      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 counted from the output end: bits 0,2,3,5 of a right shifter.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle, reloads the seed
// while reset_n is high.
module game_lfsr
  import game_pkg::*;
(
  input  logic        osc_clk,
  input  logic        reset_n,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge osc_clk or posedge reset_n) begin
    if (reset_n) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/led_sequence_game.sv
// Memory ("Simon") game: plays back a growing random LED sequence and checks
// button presses. Define GAME_TIMEOUT_EN to lose after TMO_CYC idle INPUT cycles.
module led_sequence_game
  import game_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int MAX_LEN  = 8,
  parameter int SHOW_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int TMO_CYC  = 64
) (
  input  logic                         osc_clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [N_CH-1:0]              btn,
  output logic [N_CH-1:0]              led,
  output logic                         busy,
  output logic                         win,
  output logic                         lose,
  output logic [$clog2(MAX_LEN+1)-1:0] score
);

  localparam int IDX_W   = $clog2(N_CH);
  localparam int LEN_W   = $clog2(MAX_LEN+1);
  localparam int PB_MAX  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  // One timer serves playback pacing and, when enabled, the INPUT timeout.
  localparam int TIM_MAX = (TMO_CYC > PB_MAX) ? TMO_CYC : PB_MAX;
  localparam int TIM_W   = $clog2(TIM_MAX+1);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TOP = LEN_W'(MAX_LEN);
  localparam logic [TIM_W-1:0] TIM_ONE = TIM_W'(1);
  localparam logic [TIM_W-1:0] SHOW_LAST = TIM_W'(SHOW_CYC-1);
  localparam logic [TIM_W-1:0] GAP_LAST  = TIM_W'(GAP_CYC-1);

  state_e                         state_q, state_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [LEN_W-1:0]               pos_q, pos_d;
  logic [LEN_W-1:0]               score_q, score_d;
  logic [TIM_W-1:0]               tim_q, tim_d;
  logic [MAX_LEN-1:0][IDX_W-1:0]  seq_q, seq_d;
  logic [N_CH-1:0]                btn_q;

  logic [15:0]                    rnd;
  logic [IDX_W-1:0]               new_idx;
  logic [IDX_W-1:0]               cur_idx;
  logic [N_CH-1:0]                cur_onehot;
  logic [N_CH-1:0]                press;
  logic                           press_ok;
  logic                           press_bad;
  logic                           last_pos;

  game_lfsr u_lfsr (
    .osc_clk (osc_clk),
    .reset_n (reset_n),
    .value   (rnd)
  );

  assign new_idx = IDX_W'(rnd % 16'(N_CH));

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (pos_q == LEN_W'(i)) cur_idx = seq_q[i];
  end

  assign cur_onehot = N_CH'(1) << cur_idx;
  assign press      = btn & ~btn_q;
  // Exactly one edge on the expected channel; anything else nonzero is a miss.
  assign press_ok   = (press == cur_onehot);
  assign press_bad  = (press != '0) && !press_ok;
  assign last_pos   = (pos_q == len_q - LEN_ONE);

  always_ff @(posedge osc_clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      pos_q   <= '0;
      score_q <= '0;
      tim_q   <= '0;
      seq_q   <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      score_q <= score_d;
      tim_q   <= tim_d;
      seq_q   <= seq_d;
      btn_q   <= btn;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    score_d = score_q;
    tim_d   = tim_q;
    seq_d   = seq_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          len_d   = '0;
          pos_d   = '0;
          score_d = '0;
          tim_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < MAX_LEN; i++)
          if (len_q == LEN_W'(i)) seq_d[i] = new_idx;
        len_d   = len_q + LEN_ONE;
        pos_d   = '0;
        tim_d   = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tim_q == SHOW_LAST) begin
          tim_d   = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          tim_d = tim_q + TIM_ONE;
        end
      end
      ST_SHOW_OFF: begin
        if (tim_q == GAP_LAST) begin
          tim_d = '0;
          if (!last_pos) begin
            pos_d   = pos_q + LEN_ONE;
            state_d = ST_SHOW_ON;
          end else begin
            pos_d   = '0;
            state_d = ST_INPUT;
          end
        end else begin
          tim_d = tim_q + TIM_ONE;
        end
      end
      ST_INPUT: begin
        if (press_ok) begin
          tim_d = '0;
          if (last_pos) begin
            score_d = len_q;
            state_d = (len_q == LEN_TOP) ? ST_WIN : ST_ADD;
          end else begin
            pos_d = pos_q + LEN_ONE;
          end
        end else if (press_bad) begin
          state_d = ST_LOSE;
        end
`ifdef GAME_TIMEOUT_EN
        else if (tim_q == TIM_W'(TMO_CYC-1)) begin
          state_d = ST_LOSE;
        end else begin
          tim_d = tim_q + TIM_ONE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led  = '0;
    busy = 1'b1;
    win  = 1'b0;
    lose = 1'b0;
    case (state_q)
      ST_IDLE:    busy = 1'b0;
      ST_SHOW_ON: led  = cur_onehot;
      ST_INPUT:   led  = btn;
      ST_WIN: begin
        busy = 1'b0;
        win  = 1'b1;
        led  = '1;
      end
      ST_LOSE: begin
        busy = 1'b0;
        lose = 1'b1;
      end
      ST_ADD, ST_SHOW_OFF: led = '0;
      default: busy = 1'b0;
    endcase
  end

  assign score = score_q;

endmodule
